// File: rtl/sram_bank_if.sv
// sram_bank_if: request/response and array-phase signals of the SRAM bank controller
interface sram_bank_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [DEPTH-1:0]  wl;
  logic              rd_pulse;
  logic              wr_pulse;
  logic              rsp_perr;
  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, wl, rd_pulse, wr_pulse, rsp_perr
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, wl, rd_pulse, wr_pulse, rsp_perr
  );
endinterface

// File: rtl/sram_bank_ctrl.sv
// sram_bank_ctrl: DEPTH x DATA_W SRAM bank with precharge/access/release sequencer; SRAM_PARITY_EN adds per-word even parity
module sram_bank_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int DEPTH     = 16,
  parameter int PULSE_CYC = 1
) (
  input logic      clk,
  input logic      rst_n,
  sram_bank_if.slave bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PRECH   = 2'd1;
  localparam logic [1:0] ACCESS  = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;
  localparam int CNT_W = PULSE_CYC > 1 ? $clog2(PULSE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);
  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q, sense;
  logic [DATA_W-1:0] true_q [DEPTH];
  logic [DATA_W-1:0] bar_q  [DEPTH];
  logic              fire, access, done, in_rng;
  assign fire   = bus.req_valid && bus.req_ready;
  assign access = state_q == ACCESS;
  assign done   = access && cnt_q == CNT_LAST;
  assign in_rng = {1'b0, addr_q} < DEPTH_A;
  // differential sense: a healthy cell has bar = ~true, so this yields the true rail
  assign sense  = in_rng ? (true_q[addr_q] & ~bar_q[addr_q]) : '0;
  assign bus.req_ready = state_q == IDLE;
  assign bus.rsp_valid = state_q == RELEASE;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rd_pulse  = access && !we_q;
  assign bus.wr_pulse  = access && we_q;
  assign bus.wl        = (access && in_rng) ? (DEPTH'(1) << addr_q) : '0;
  // sequencer next state and ACCESS pulse-width counter
  always_comb begin
    state_d = state_q == IDLE   ? (fire ? PRECH : IDLE) :
              state_q == PRECH  ? ACCESS :
              state_q == ACCESS ? (done ? RELEASE : ACCESS) : IDLE;
    cnt_d   = (access && !done) ? cnt_q + 1'b1 : '0;
  end
  // control state, latched request and read-data register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (fire) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (done && !we_q) rdata_q <= sense;
    end
  end
  // cell array: commits on the falling edge of wr_pulse, out-of-range writes dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        true_q[i] <= '0;
        bar_q[i]  <= '1;
      end
    end else if (done && we_q && in_rng) begin
      true_q[addr_q] <= wdata_q;
      bar_q[addr_q]  <= ~wdata_q;
    end
  end
`ifdef SRAM_PARITY_EN
  logic par_q [DEPTH];
  logic perr_q;
  // parity bit stored with the word; checked against sensed data on read completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) par_q[i] <= 1'b0;
      perr_q <= 1'b0;
    end else if (done) begin
      if (we_q && in_rng) par_q[addr_q] <= ^wdata_q;
      perr_q <= !we_q && in_rng && (par_q[addr_q] != ^sense);
    end
  end
  assign bus.rsp_perr = bus.rsp_valid && perr_q;
`else
  assign bus.rsp_perr = 1'b0;
`endif
endmodule

// File: tb/tb_sram_bank_ctrl.sv
// tb_sram_bank_ctrl: randomized self-checking bench for sram_bank_ctrl (DEPTH=12, PULSE_CYC=3)
module tb_sram_bank_ctrl;
  localparam int DW = 8, AW = 4, DEPTH = 12, PULSE = 3;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  sram_bank_if #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) bus ();
  sram_bank_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .PULSE_CYC(PULSE)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  int n_cmp = 0, n_err = 0;
  logic [7:0] mem_m [16];
  logic [7:0] last_rd;

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
    last_rd = 8'h00;
  endtask

  // one transaction: timeline expected from the phase rules (PRECH 1, ACCESS PULSE, RELEASE 1)
  task automatic do_op(input logic we, input logic [3:0] a, input logic [7:0] d, input bit junk, input bit perr);
    logic [DEPTH+4:0] obs, exp_v;
    logic [7:0] exp_rd;
    bit acc;
    int k;
    k = 0;
    while (bus.req_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_wait: req_ready=%b required 1", bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(posedge clk);
    #1;
    bus.req_valid = junk;
    bus.req_we    = 1'b1;
    bus.req_wdata = ~d;
    exp_rd = we ? last_rd : (int'(a) < DEPTH ? mem_m[a] : 8'h00);
    for (int c = 1; c <= PULSE + 3; c++) begin
      @(negedge clk);
      acc = c >= 2 && c <= PULSE + 1;
      exp_v = {c == PULSE + 3, c == PULSE + 2, acc && !we, acc && we, c == PULSE + 2 && perr,
               (acc && int'(a) < DEPTH) ? (DEPTH'(1) << a) : DEPTH'(0)};
      obs = {bus.req_ready, bus.rsp_valid, bus.rd_pulse, bus.wr_pulse, bus.rsp_perr, bus.wl};
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL op_phase %s a=%0d c=%0d: {rdy,rsp,rd,wr,perr,wl} got %h required %h",
                 we ? "wr" : "rd", a, c, obs, exp_v);
      end
      if (c == PULSE + 2) begin
        n_cmp++;
        if (bus.rsp_rdata !== exp_rd) begin
          n_err++;
          $display("FAIL rsp_rdata %s a=%0d: got %h required %h", we ? "wr" : "rd", a, bus.rsp_rdata, exp_rd);
        end
        bus.req_valid = 1'b0;
      end
    end
    if (we && int'(a) < DEPTH) mem_m[a] = d;
    last_rd = exp_rd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.req_ready, bus.rsp_valid, bus.rd_pulse, bus.wr_pulse, bus.rsp_perr, bus.wl} !== {1'b1, 4'b0, DEPTH'(0)}) begin
      n_err++;
      $display("FAIL reset_outputs: rdy=%b rsp=%b rd=%b wr=%b perr=%b wl=%h required rdy=1 others 0",
               bus.req_ready, bus.rsp_valid, bus.rd_pulse, bus.wr_pulse, bus.rsp_perr, bus.wl);
    end
    n_cmp++;
    if (bus.rsp_rdata !== 8'h00) begin
      n_err++;
      $display("FAIL reset_rdata: got %h required 00", bus.rsp_rdata);
    end
    rst_n = 1'b1;
    model_clear();
    do_op(1'b0, 4'd3, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_write_read();
    do_op(1'b1, 4'd5, 8'hA5, 1'b0, 1'b0);
    do_op(1'b0, 4'd5, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_pulse();
    do_op(1'b1, 4'd0, 8'h3C, 1'b0, 1'b0);
    do_op(1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_out_of_range();
    do_op(1'b1, 4'd14, 8'hFF, 1'b0, 1'b0);
    do_op(1'b0, 4'd14, 8'h00, 1'b0, 1'b0);
    do_op(1'b0, 4'd11, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_busy_ignore();
    do_op(1'b1, 4'd9, 8'h5A, 1'b0, 1'b0);
    do_op(1'b0, 4'd9, 8'h00, 1'b1, 1'b0);
    do_op(1'b0, 4'd9, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++)
      do_op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom), 1'b0, 1'b0);
  endtask

  task automatic test_reset_abort();
    int seen;
    do_op(1'b1, 4'd2, 8'h11, 1'b0, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 4'd2;
    bus.req_wdata = 8'h22;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.req_ready, bus.rsp_valid, bus.rd_pulse, bus.wr_pulse, bus.wl} !== {1'b1, 3'b0, DEPTH'(0)}) begin
      n_err++;
      $display("FAIL abort_async: rdy=%b rsp=%b rd=%b wr=%b wl=%h required rdy=1 others 0",
               bus.req_ready, bus.rsp_valid, bus.rd_pulse, bus.wr_pulse, bus.wl);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL abort_no_rsp: rsp_valid pulses got %0d required 0", seen);
    end
    do_op(1'b0, 4'd2, 8'h00, 1'b0, 1'b0);
  endtask

`ifdef SRAM_PARITY_EN
  task automatic test_parity();
    do_op(1'b1, 4'd7, 8'h81, 1'b0, 1'b0);
    dut.true_q[7][0] = ~dut.true_q[7][0];
    mem_m[7] = 8'h80;
    do_op(1'b0, 4'd7, 8'h00, 1'b0, 1'b1);
    do_op(1'b1, 4'd8, 8'h42, 1'b0, 1'b0);
    do_op(1'b0, 4'd8, 8'h00, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_pulse();
    test_out_of_range();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
`ifdef SRAM_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
